// File: rtl/amba_axi4_stream_pkt_source.sv
// rtl/amba_axi4_stream_pkt_source.sv - AXI4-Stream packet source driven by a length/id/dest/seed command
module amba_axi4_stream_pkt_source #(
    parameter int DATA_BYTES = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_bytes,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [DEST_WIDTH-1:0]   cmd_dest,
    input  logic [7:0]              cmd_seed,
    output logic [8*DATA_BYTES-1:0] TDATA,
    output logic [DATA_BYTES-1:0]   TSTRB,
    output logic [DATA_BYTES-1:0]   TKEEP,
    output logic                    TLAST,
    output logic [ID_WIDTH-1:0]     TID,
    output logic [DEST_WIDTH-1:0]   TDEST,
    output logic [USER_WIDTH-1:0]   TUSER,
    output logic                    TVALID,
    input  logic                    TREADY,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    cmd_err
);

    localparam logic [LEN_WIDTH:0] DB_L     = (LEN_WIDTH + 1)'(DATA_BYTES);
    localparam logic [7:0]         GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 state_q, state_d;
    logic                   rst_done_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [LEN_WIDTH-1:0]   beat_cnt_q;
    logic [7:0]             base_q;
    logic [7:0]             gap_cnt_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [DEST_WIDTH-1:0]  dest_q;
    logic                   pkt_done_q;
    logic                   cmd_err_q;
    logic                   accept;
    logic                   send;
    logic                   hs;
    logic                   last_beat;

    assign cmd_ready = rst_done_q && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign send      = (state_q == S_SEND);
    assign hs        = send && TREADY;
    // rem_q holds the bytes still to send, so the current beat is last once it fits
    assign last_beat = ({1'b0, rem_q} <= DB_L);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_bytes != '0)
                        state_d = S_SEND;
                    else if (GAP_CYCLES > 0)
                        state_d = S_GAP;
                end
            end
            S_SEND: begin
                if (hs && last_beat)
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rst_done_q <= 1'b0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            base_q     <= 8'd0;
            gap_cnt_q  <= 8'd0;
            id_q       <= '0;
            dest_q     <= '0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            pkt_done_q <= hs && last_beat;
            cmd_err_q  <= accept && (cmd_bytes == '0);
            gap_cnt_q  <= (state_q == S_GAP) ? gap_cnt_q + 8'd1 : 8'd0;
            if (accept && (cmd_bytes != '0)) begin
                rem_q      <= cmd_bytes;
                beat_cnt_q <= '0;
                base_q     <= cmd_seed;
                id_q       <= cmd_id;
                dest_q     <= cmd_dest;
            end else if (hs && !last_beat) begin
                rem_q      <= rem_q - LEN_WIDTH'(DATA_BYTES);
                beat_cnt_q <= beat_cnt_q + 1'b1;
                base_q     <= base_q + 8'(DATA_BYTES);
            end
        end
    end

    // Outputs derive only from state that changes on a handshake, so they hold under backpressure
    always_comb begin
        TDATA = '0;
        TKEEP = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (send && ({1'b0, rem_q} > (LEN_WIDTH + 1)'(j))) begin
                TKEEP[j]       = 1'b1;
                TDATA[8*j +: 8] = base_q + 8'(j);
            end
        end
        TSTRB = TKEEP;
    end

    always_comb begin
        TUSER    = '0;
        TUSER[0] = send && (beat_cnt_q == '0);
    end

    assign TLAST    = send && last_beat;
    assign TID      = send ? id_q : '0;
    assign TDEST    = send ? dest_q : '0;
    assign TVALID   = send;
    assign busy     = (state_q != S_IDLE);
    assign pkt_done = pkt_done_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_amba_axi4_stream_pkt_source.sv
// tb/tb_amba_axi4_stream_pkt_source.sv - directed vector bench for amba_axi4_stream_pkt_source
module tb_amba_axi4_stream_pkt_source;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid_g = 1'b0;
    logic [15:0] cmd_bytes = 16'd0;
    logic [3:0]  cmd_id = 4'd0;
    logic [3:0]  cmd_dest = 4'd0;
    logic [7:0]  cmd_seed = 8'd0;
    logic        tready = 1'b0;

    logic        cmd_ready, tlast, tvalid, busy, pkt_done, cmd_err;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep, tid, tdest;
    logic [0:0]  tuser;

    logic        cmd_ready_g, tlast_g, tvalid_g, busy_g, pkt_done_g, cmd_err_g;
    logic [31:0] tdata_g;
    logic [3:0]  tstrb_g, tkeep_g, tid_g, tdest_g;
    logic [0:0]  tuser_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amba_axi4_stream_pkt_source #(.DATA_BYTES(4), .GAP_CYCLES(0)) dut (
        .ACLK(clk), .ARESETn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_bytes(cmd_bytes), .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_seed(cmd_seed),
        .TDATA(tdata), .TSTRB(tstrb), .TKEEP(tkeep), .TLAST(tlast), .TID(tid),
        .TDEST(tdest), .TUSER(tuser), .TVALID(tvalid), .TREADY(tready),
        .busy(busy), .pkt_done(pkt_done), .cmd_err(cmd_err)
    );

    amba_axi4_stream_pkt_source #(.DATA_BYTES(4), .GAP_CYCLES(3)) dut_g (
        .ACLK(clk), .ARESETn(aresetn), .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g),
        .cmd_bytes(cmd_bytes), .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_seed(cmd_seed),
        .TDATA(tdata_g), .TSTRB(tstrb_g), .TKEEP(tkeep_g), .TLAST(tlast_g), .TID(tid_g),
        .TDEST(tdest_g), .TUSER(tuser_g), .TVALID(tvalid_g), .TREADY(tready),
        .busy(busy_g), .pkt_done(pkt_done_g), .cmd_err(cmd_err_g)
    );

    typedef struct {
        logic [15:0]      bytes;
        logic [7:0]       seed;
        logic [3:0]       id;
        logic [3:0]       dest;
        int               nbeats;
        logic [2:0][31:0] data;
        logic [3:0]       last_keep;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input logic [15:0] b, input logic [7:0] s, input logic [3:0] i,
                                input logic [3:0] d, input int n, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] lk);
        vec_t v;
        v.bytes = b; v.seed = s; v.id = i; v.dest = d; v.nbeats = n;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.last_keep = lk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        cmd_valid = 1'b1; cmd_bytes = v.bytes; cmd_seed = v.seed; cmd_id = v.id; cmd_dest = v.dest;
        chk($sformatf("v%0d_idle_ready", i), cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            chk($sformatf("v%0d_b%0d_tvalid", i, b), tvalid, 1);
            chk($sformatf("v%0d_b%0d_tdata", i, b), tdata, v.data[b]);
            chk($sformatf("v%0d_b%0d_tkeep", i, b), tkeep, (b == v.nbeats - 1) ? v.last_keep : 4'hF);
            chk($sformatf("v%0d_b%0d_tstrb", i, b), tstrb, (b == v.nbeats - 1) ? v.last_keep : 4'hF);
            chk($sformatf("v%0d_b%0d_tlast", i, b), tlast, (b == v.nbeats - 1) ? 1 : 0);
            chk($sformatf("v%0d_b%0d_tuser", i, b), tuser, (b == 0) ? 1 : 0);
            chk($sformatf("v%0d_b%0d_tid", i, b), tid, v.id);
            chk($sformatf("v%0d_b%0d_tdest", i, b), tdest, v.dest);
            chk($sformatf("v%0d_b%0d_cmd_ready", i, b), cmd_ready, 0);
            chk($sformatf("v%0d_b%0d_pkt_done", i, b), pkt_done, 0);
            @(posedge clk); @(negedge clk);
        end
        chk($sformatf("v%0d_end_tvalid", i), tvalid, 0);
        chk($sformatf("v%0d_end_pkt_done", i), pkt_done, 1);
        chk($sformatf("v%0d_end_ready", i), cmd_ready, 1);
        @(negedge clk);
        chk($sformatf("v%0d_pkt_done_clear", i), pkt_done, 0);
    endtask

    initial begin
        logic [5:0]  tr_pat;
        logic [31:0] prev_data;
        logic        prev_stall;
        int          b, hs, gap;

        vecs[0] = mk(16'd10, 8'h10, 4'd3, 4'd5, 3, 32'h13121110, 32'h17161514, 32'h00001918, 4'h3);
        vecs[1] = mk(16'd4,  8'hFE, 4'd1, 4'd2, 1, 32'h0100FFFE, 32'h0, 32'h0, 4'hF);
        vecs[2] = mk(16'd5,  8'hFD, 4'hA, 4'hC, 2, 32'h00FFFEFD, 32'h00000001, 32'h0, 4'h1);
        vecs[3] = mk(16'd8,  8'h80, 4'hF, 4'h0, 2, 32'h83828180, 32'h87868584, 32'h0, 4'hF);
        vecs[4] = mk(16'd1,  8'h55, 4'h7, 4'h8, 1, 32'h00000055, 32'h0, 32'h0, 4'h1);

        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", {tkeep, tstrb}, 0);
        chk("rst_tlast_tuser", {tlast, tuser}, 0);
        chk("rst_tid_tdest", {tid, tdest}, 0);
        chk("rst_flags", {busy, pkt_done, cmd_err}, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        aresetn = 1'b1;
        tready  = 1'b1;
        chk("rel_cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_tvalid_with_tready", tvalid, 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: payload must match vector 0 and hold on every stalled cycle
        tr_pat = 6'b110100;
        cmd_valid = 1'b1; cmd_bytes = 16'd10; cmd_seed = 8'h10; cmd_id = 4'd3; cmd_dest = 4'd5;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        b = 0; hs = 0; prev_stall = 1'b0; prev_data = 32'h0;
        for (int k = 0; k < 6; k++) begin
            tready = tr_pat[k];
            chk($sformatf("stall_k%0d_tvalid", k), tvalid, 1);
            chk($sformatf("stall_k%0d_tdata", k), tdata, vecs[0].data[b]);
            chk($sformatf("stall_k%0d_tlast", k), tlast, (b == 2) ? 1 : 0);
            if (prev_stall) chk($sformatf("stall_k%0d_stable", k), tdata, prev_data);
            prev_stall = !tr_pat[k];
            prev_data  = tdata;
            if (tvalid && tready) begin hs++; b++; end
            @(posedge clk); @(negedge clk);
        end
        chk("stall_handshakes", hs, 3);
        chk("stall_end_tvalid", tvalid, 0);
        chk("stall_pkt_done", pkt_done, 1);
        tready = 1'b1;
        @(negedge clk);

        // Zero-length command
        cmd_valid = 1'b1; cmd_bytes = 16'd0; cmd_seed = 8'h33;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk("zero_cmd_err", cmd_err, 1);
        chk("zero_tvalid", tvalid, 0);
        chk("zero_ready", cmd_ready, 1);
        @(negedge clk);
        chk("zero_cmd_err_clear", cmd_err, 0);
        chk("zero_tvalid_after", tvalid, 0);

        // Reset during beat 1 of a 5-beat packet
        cmd_valid = 1'b1; cmd_bytes = 16'd20; cmd_seed = 8'h00; cmd_id = 4'd2; cmd_dest = 4'd9;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk("mr_b0_tdata", tdata, 32'h03020100);
        @(posedge clk); @(negedge clk);
        chk("mr_b1_tdata", tdata, 32'h07060504);
        chk("mr_b1_tuser", tuser, 0);
        aresetn = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mr_tvalid", tvalid, 0);
        chk("mr_outputs", {tdata, tkeep, tstrb, tlast, tuser, tid, tdest}, 0);
        chk("mr_flags", {busy, pkt_done, cmd_ready}, 0);
        aresetn = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mr_ready_after", cmd_ready, 1);
        run_vec(0);

        // GAP_CYCLES=3 with a second command already waiting
        cmd_valid_g = 1'b1; cmd_bytes = 16'd4; cmd_seed = 8'h20; cmd_id = 4'd6; cmd_dest = 4'd7;
        chk("gap_ready_idle", cmd_ready_g, 1);
        @(posedge clk); @(negedge clk);
        chk("gap_p1_tdata", tdata_g, 32'h23222120);
        chk("gap_p1_last_sop", {tlast_g, tuser_g}, 2'b11);
        @(posedge clk); @(negedge clk);
        chk("gap_pkt_done", pkt_done_g, 1);
        gap = 0;
        while (!tvalid_g && gap < 20) begin
            if (gap < 3) chk($sformatf("gap_c%0d_ready", gap), {cmd_ready_g, busy_g}, 2'b01);
            gap++;
            @(negedge clk);
        end
        chk("gap_idle_cycles", gap, 4);
        cmd_valid_g = 1'b0;
        chk("gap_p2_tdata", tdata_g, 32'h23222120);
        chk("gap_p2_sop", tuser_g, 1);
        @(posedge clk); @(negedge clk);
        chk("gap_p2_done_busy", {pkt_done_g, busy_g, tvalid_g}, 3'b110);
        repeat (4) @(negedge clk);
        chk("gap_back_idle", {busy_g, cmd_ready_g}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
